// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data memory port initiator for the MEM stage (optional MISALIGN_TRAP_EN)
module load_store_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [2:0]            mem_funct3,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam int CW = $clog2(READ_LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic            accept;
    logic            funct3_legal;
    logic            misaligned;
    logic            req_bad;

    assign accept = req_valid & req_ready;

    // Classify the incoming request: illegal encodings (and optionally misaligned accesses) go to the error path
    always_comb begin
        funct3_legal = 1'b0;
        misaligned   = 1'b0;
        if (req_is_store) begin
            funct3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            funct3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                           (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
`ifdef MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3 == 3'b010) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
`endif
        req_bad = !funct3_legal || misaligned;
    end

    // Next-state and strobe decode; strobes depend on state only
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_bad) begin
                        state_nxt = S_RESP;
                    end else if (req_is_store) begin
                        state_nxt = S_STORE;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_STORE: begin
                mem_write = 1'b1;
                state_nxt = S_RESP;
            end
            S_LOAD: begin
                mem_read = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read-latency counter: restarts on accept, saturates at the last load cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == S_LOAD && cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Request latch (held until the next accept) and response data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_funct3     <= '0;
            err_q          <= 1'b0;
            resp_data      <= '0;
        end else if (accept) begin
            mem_address    <= req_addr;
            mem_write_data <= req_wdata;
            mem_funct3     <= req_funct3;
            err_q          <= req_bad;
            resp_data      <= '0;
        end else if (state == S_CAPTURE) begin
            resp_data      <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_funct3;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data = 32'h0;

    logic        req_valid3 = 1'b0;
    logic        req_ready3;
    logic        resp_valid3;
    logic [31:0] resp_data3;
    logic        resp_err3;
    logic [31:0] mem_address3;
    logic [31:0] mem_write_data3;
    logic [2:0]  mem_funct33;
    logic        mem_write3;
    logic        mem_read3;
    logic [31:0] mem_read_data3 = 32'h0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_funct3(mem_funct3), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_is_store(1'b0), .req_funct3(3'b010), .req_addr(32'h10),
        .req_wdata(32'h0), .resp_valid(resp_valid3), .resp_data(resp_data3),
        .resp_err(resp_err3), .mem_address(mem_address3), .mem_write_data(mem_write_data3),
        .mem_funct3(mem_funct33), .mem_write(mem_write3), .mem_read(mem_read3),
        .mem_read_data(mem_read_data3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Toy data memory: stores overwrite the word at that exact address, otherwise an address-derived pattern
    logic [31:0] store_mem [logic [31:0]];

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (store_mem.exists(a)) return store_mem[a];
        return {a[15:0], 16'hA5C3};
    endfunction

    always @(posedge clk) begin
        if (mem_write) store_mem[mem_address] = mem_write_data;
        if (mem_read) mem_read_data <= memval(mem_address);
        if (mem_read3) mem_read_data3 <= 32'h1234_5678;
    end

    // Behavioural model: each accepted request becomes a schedule of expected cycles
    int cyc = 0;
    int idle_from = 0;
    int wr_c = -1, rd_lo = -1, rd_hi = -2, resp_c = -1;
    logic        e_err = 1'b0;
    logic [31:0] e_data = 32'h0, e_addr = 32'h0, e_wdata = 32'h0;
    logic [2:0]  e_f3 = 3'b000;
    int acc_q[$];

    function automatic logic is_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        if (st) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'b001 || (!st && f3 == 3'b101)) && a[0]) bad = 1'b1;
        if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    always @(posedge clk) begin
        int base;
        if (rst) begin
            idle_from = 0; wr_c = -1; rd_lo = -1; rd_hi = -2; resp_c = -1;
            e_addr = 0; e_wdata = 0; e_f3 = 0;
        end else if (req_valid && cyc >= idle_from) begin
            base = cyc;
            acc_q.push_back(base);
            e_addr = req_addr; e_wdata = req_wdata; e_f3 = req_funct3;
            wr_c = -1; rd_lo = -1; rd_hi = -2;
            if (is_bad(req_is_store, req_funct3, req_addr)) begin
                resp_c = base + 1; e_err = 1'b1; e_data = 0; idle_from = base + 2;
            end else if (req_is_store) begin
                wr_c = base + 1; resp_c = base + 2; e_err = 1'b0; e_data = 0; idle_from = base + 3;
            end else begin
                rd_lo = base + 1; rd_hi = base + RL; resp_c = base + RL + 2;
                e_err = 1'b0; e_data = memval(req_addr); idle_from = base + RL + 3;
            end
        end
        cyc++;
    end

    // Every-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_read", {31'b0, mem_read}, 0);
            chk("rst_mem_write", {31'b0, mem_write}, 0);
            chk("rst_resp_valid", {31'b0, resp_valid}, 0);
            chk("rst_resp_err", {31'b0, resp_err}, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_mem_address", mem_address, 0);
            chk("rst_mem_write_data", mem_write_data, 0);
            chk("rst_mem_funct3", {29'b0, mem_funct3}, 0);
        end else begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, cyc >= idle_from});
            chk("mem_read", {31'b0, mem_read}, {31'b0, (cyc >= rd_lo && cyc <= rd_hi)});
            chk("mem_write", {31'b0, mem_write}, {31'b0, cyc == wr_c});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, cyc == resp_c});
            if (cyc == resp_c) begin
                chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
                chk("resp_data", resp_data, e_data);
            end else begin
                chk("resp_err_idle", {31'b0, resp_err}, 0);
            end
            chk("mem_address", mem_address, e_addr);
            chk("mem_write_data", mem_write_data, e_wdata);
            chk("mem_funct3", {29'b0, mem_funct3}, {29'b0, e_f3});
        end
    end

    // Present a request and return 1 ns after the accepting edge (spec cycle 1)
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic hold);
        bit ok = 0;
        req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout: req_ready never rose within 20 cycles");
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        idle_cycles(2);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, req_ready}, 1);
        idle_cycles(1);

        // SW 0x10 <- DEADBEEF: write in cycle 1 only, response in cycle 2
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("sw_write_c1", {31'b0, mem_write}, 1);
        chk("sw_addr_c1", mem_address, 32'h10);
        idle_cycles(1);
        chk("sw_write_c2", {31'b0, mem_write}, 0);
        chk("sw_resp_c2", {31'b0, resp_valid}, 1);
        chk("sw_data_c2", resp_data, 0);
        idle_cycles(3);

        // LW 0x10: reads cycles 1-2, response cycle 4 with the stored word
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("lw_read_c1", {31'b0, mem_read}, 1);
        idle_cycles(2);
        chk("lw_read_c3", {31'b0, mem_read}, 0);
        chk("lw_resp_c3", {31'b0, resp_valid}, 0);
        idle_cycles(1);
        chk("lw_resp_c4", {31'b0, resp_valid}, 1);
        chk("lw_data_c4", resp_data, 32'hDEADBEEF);
        idle_cycles(2);

        // Illegal load funct3 011: immediate error response, no strobe
        do_req(1'b0, 3'b011, 32'h40, 32'h0, 1'b0);
        chk("ill_resp_c1", {31'b0, resp_valid}, 1);
        chk("ill_err_c1", {31'b0, resp_err}, 1);
        chk("ill_nostrobe", {30'b0, mem_read, mem_write}, 0);
        idle_cycles(3);

        // Illegal store funct3 100
        do_req(1'b1, 3'b100, 32'h44, 32'h55, 1'b0);
        chk("ill_st_err_c1", {31'b0, resp_err}, 1);
        idle_cycles(3);

        // LH 0x13: trapped when alignment checking is built in, otherwise a normal load
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("lh_mis_err_c1", {31'b0, resp_err}, 1);
        chk("lh_mis_noread", {31'b0, mem_read}, 0);
`else
        chk("lh_mis_read_c1", {31'b0, mem_read}, 1);
        chk("lh_mis_addr", mem_address, 32'h13);
`endif
        idle_cycles(6);

        // Assorted loads and stores
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 1'b0);  idle_cycles(6);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);  idle_cycles(6);
        do_req(1'b1, 3'b001, 32'h30, 32'hCAFE_F00D, 1'b0); idle_cycles(4);
        do_req(1'b0, 3'b000, 32'h30, 32'h0, 1'b0);  idle_cycles(6);
        do_req(1'b1, 3'b010, 32'h32, 32'h1111_2222, 1'b0); idle_cycles(6);

        // SB then LBU with req_valid held: second accept exactly 3 cycles later
        acc_q.delete();
        do_req(1'b1, 3'b000, 32'h50, 32'h0000_00AB, 1'b1);
        do_req(1'b0, 3'b100, 32'h50, 32'h0, 1'b0);
        if (acc_q.size() == 2) chk("b2b_gap", acc_q[1] - acc_q[0], 3);
        else chk("b2b_accepts", acc_q.size(), 2);
        idle_cycles(6);

        // Reset in load cycle 1: read strobe drops at once, no response afterwards
        do_req(1'b0, 3'b010, 32'h60, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1 chk("rst_drops_read", {31'b0, mem_read}, 0);
        @(posedge clk); #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("rst_no_resp", pulses, 0);
        chk("rst_ready_after", {31'b0, req_ready}, 1);
        idle_cycles(1);

        // READ_LATENCY=3 instance: reads cycles 1-3, response cycle 5
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("rl3_read_c%0d", c), {31'b0, mem_read3}, {31'b0, c <= 3});
            chk($sformatf("rl3_resp_c%0d", c), {31'b0, resp_valid3}, {31'b0, c == 5});
            if (c == 5) chk("rl3_data", resp_data3, 32'h1234_5678);
            @(posedge clk); #1;
        end

        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
